// File: rtl/wb_riot_timer.sv
// 6532 RIOT interval timer as an 8-bit Wishbone responder, counting on tick_i.
// Optional interrupt output is enabled by defining WB_RIOT_IRQ_EN.
module wb_riot_timer #(
    parameter logic [7:0] RESET_COUNT        = 8'h00,
    parameter logic [1:0] RESET_INTERVAL_SEL = 2'd3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [4:0] adr_i,
    input  logic [7:0] dat_i,
    output logic       ack_o,
    output logic [7:0] dat_o,
    input  logic       tick_i
`ifdef WB_RIOT_IRQ_EN
    ,
    output logic       irq_o
`endif
);

    logic       ack_q, ack_d;
    logic [7:0] dat_q, dat_d;
    logic [7:0] count_q, count_d;
    logic [1:0] interval_q, interval_d;
    logic [9:0] prescale_q, prescale_d;
    logic       flag_q, flag_d;
    logic       accept, wr_tmr, rd_acc;
    logic [9:0] limit;
    logic       unused_adr;

    assign unused_adr = ^adr_i[3:1];

    always_comb begin
        accept     = stb_i & ~ack_q;
        wr_tmr     = accept & we_i & adr_i[4];
        rd_acc     = accept & ~we_i;
        ack_d      = accept;
        dat_d      = dat_q;
        count_d    = count_q;
        interval_d = interval_q;
        prescale_d = prescale_q;
        flag_d     = flag_q;

        case (interval_q)
            2'd0:    limit = 10'd0;
            2'd1:    limit = 10'd7;
            2'd2:    limit = 10'd63;
            default: limit = 10'd1023;
        endcase
        // After underflow the timer free-runs at one decrement per tick.
        if (flag_q) limit = 10'd0;

        if (rd_acc) begin
            dat_d = adr_i[0] ? {flag_q, 7'b0} : count_q;
            if (!adr_i[0]) flag_d = 1'b0;
        end

        if (wr_tmr) begin
            count_d    = dat_i;
            interval_d = adr_i[1:0];
            prescale_d = '0;
            flag_d     = 1'b0;
        end else if (tick_i) begin
            if (prescale_q == limit) begin
                prescale_d = '0;
                count_d    = count_q - 8'd1;
                if (count_q == 8'h00) flag_d = 1'b1;
            end else begin
                prescale_d = prescale_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= 8'h00;
            count_q    <= RESET_COUNT;
            interval_q <= RESET_INTERVAL_SEL;
            prescale_q <= '0;
            flag_q     <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            count_q    <= count_d;
            interval_q <= interval_d;
            prescale_q <= prescale_d;
            flag_q     <= flag_d;
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;

`ifdef WB_RIOT_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_tmr) irq_en_d = adr_i[3];
        irq_d = flag_d & irq_en_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_wb_riot_timer.sv
// Bench for wb_riot_timer: vector table, directed corner sequences and a
// randomized run against a tick-count based reference model.
module tb_wb_riot_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       stb;
    logic       we;
    logic [4:0] adr;
    logic [7:0] dat_i;
    logic       tick;
    logic       ack;
    logic [7:0] dat_o;
`ifdef WB_RIOT_IRQ_EN
    logic       irq;
    bit         m_en;
`endif

    always #5 clk = ~clk;

    wb_riot_timer dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .stb_i  (stb),
        .we_i   (we),
        .adr_i  (adr),
        .dat_i  (dat_i),
        .ack_o  (ack),
        .dat_o  (dat_o),
        .tick_i (tick)
`ifdef WB_RIOT_IRQ_EN
        ,
        .irq_o  (irq)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: timer state is (load value, divisor, ticks since load).
    // Before underflow the value is v - n/D; from tick (v+1)*D on, the
    // value drops by one per tick from FF with the flag set.
    int         m_v, m_d, m_n;
    bit         m_ack;
    logic [7:0] m_dat;

    function automatic int divsel(input logic [1:0] s);
        if (s == 2'd3) return 1024;
        return 1 << (3 * int'(s));
    endfunction

    function automatic int m_k();
        return (m_v + 1) * m_d;
    endfunction

    function automatic int m_val();
        if (m_n < m_k()) return m_v - m_n / m_d;
        return 255 - ((m_n - m_k()) % 256);
    endfunction

    function automatic bit m_flag();
        return m_n >= m_k();
    endfunction

    task automatic model_reset();
        m_v = 0; m_d = 1024; m_n = 0;
        m_ack = 1'b0; m_dat = 8'h00;
`ifdef WB_RIOT_IRQ_EN
        m_en = 1'b0;
`endif
    endtask

    task automatic model_step(input bit s, input bit w, input logic [4:0] a,
                              input logic [7:0] d, input bit tk);
        bit acc;
        bit uf;
        bit cf;
        int cv;
        acc = s && !m_ack;
        uf  = 1'b0;
        cv  = m_val();
        cf  = m_flag();
        if (acc && !w) m_dat = a[0] ? {cf, 7'b0} : cv[7:0];
        if (acc && w && a[4]) begin
            m_v = int'(d); m_d = divsel(a[1:0]); m_n = 0;
`ifdef WB_RIOT_IRQ_EN
            m_en = a[3];
`endif
        end else if (tk) begin
            m_n++;
            uf = m_flag() && ((m_n - m_k()) % 256 == 0);
        end
        // A flag-clearing INTIM read restarts the countdown from the
        // current value with a fresh prescaler.
        if (acc && !w && !a[0] && m_flag() && !uf) begin
            m_v = m_val();
            m_n = 0;
        end
        m_ack = acc;
    endtask

    task automatic cyc(input bit s, input bit w, input logic [4:0] a,
                       input logic [7:0] d, input bit tk);
        @(negedge clk);
        stb = s; we = w; adr = a; dat_i = d; tick = tk;
        @(posedge clk);
        model_step(s, w, a, d, tk);
        #1;
    endtask

    task automatic idle(input bit tk);
        cyc(1'b0, 1'b0, 5'h00, 8'h00, tk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d, input bit tk);
        cyc(1'b1, 1'b1, a, d, tk);
        chk("wr_ack", {31'b0, ack}, 1);
        idle(1'b0);
    endtask

    task automatic rd(input string nm, input logic [4:0] a,
                      input logic [7:0] exp);
        cyc(1'b1, 1'b0, a, 8'h00, 1'b0);
        chk({nm, "_ack"}, {31'b0, ack}, 1);
        chk(nm, {24'b0, dat_o}, {24'b0, exp});
        idle(1'b0);
    endtask

    typedef struct {
        bit         stb;
        bit         we;
        logic [4:0] adr;
        logic [7:0] dat;
        bit         tick;
        bit         eack;
        logic [7:0] edat;
    } vec_t;

    vec_t tbl[26];
    bit   hold;
    bit   rw;
    logic [4:0] ra;
    logic [7:0] rdat;
    bit   tk;

    initial begin
        tbl[0]  = '{0, 0, 5'h00, 8'h00, 0, 0, 8'h00};
        tbl[1]  = '{1, 1, 5'h14, 8'h03, 0, 1, 8'h00};
        tbl[2]  = '{0, 0, 5'h00, 8'h00, 1, 0, 8'h00};
        tbl[3]  = '{0, 0, 5'h00, 8'h00, 1, 0, 8'h00};
        tbl[4]  = '{0, 0, 5'h00, 8'h00, 1, 0, 8'h00};
        tbl[5]  = '{1, 0, 5'h04, 8'h00, 0, 1, 8'h00};
        tbl[6]  = '{0, 0, 5'h00, 8'h00, 0, 0, 8'h00};
        tbl[7]  = '{1, 0, 5'h05, 8'h00, 0, 1, 8'h00};
        tbl[8]  = '{0, 0, 5'h00, 8'h00, 1, 0, 8'h00};
        tbl[9]  = '{1, 0, 5'h05, 8'h00, 0, 1, 8'h80};
        tbl[10] = '{0, 0, 5'h00, 8'h00, 0, 0, 8'h80};
        tbl[11] = '{1, 0, 5'h04, 8'h00, 0, 1, 8'hFF};
        tbl[12] = '{0, 0, 5'h00, 8'h00, 0, 0, 8'hFF};
        tbl[13] = '{1, 0, 5'h05, 8'h00, 0, 1, 8'h00};
        tbl[14] = '{0, 0, 5'h00, 8'h00, 1, 0, 8'h00};
        tbl[15] = '{1, 0, 5'h04, 8'h00, 0, 1, 8'hFE};
        tbl[16] = '{1, 0, 5'h04, 8'h00, 0, 0, 8'hFE};
        tbl[17] = '{1, 0, 5'h04, 8'h00, 0, 1, 8'hFE};
        tbl[18] = '{1, 0, 5'h04, 8'h00, 0, 0, 8'hFE};
        tbl[19] = '{1, 1, 5'h00, 8'h55, 0, 1, 8'hFE};
        tbl[20] = '{0, 0, 5'h00, 8'h00, 0, 0, 8'hFE};
        tbl[21] = '{1, 0, 5'h04, 8'h00, 0, 1, 8'hFE};
        tbl[22] = '{0, 0, 5'h00, 8'h00, 0, 0, 8'hFE};
        tbl[23] = '{1, 1, 5'h1B, 8'h07, 1, 1, 8'hFE};
        tbl[24] = '{0, 0, 5'h00, 8'h00, 1, 0, 8'hFE};
        tbl[25] = '{1, 0, 5'h04, 8'h00, 0, 1, 8'h07};

        rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; tick = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", {31'b0, ack}, 0);
        chk("reset_dat", {24'b0, dat_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            cyc(tbl[i].stb, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].tick);
            chk($sformatf("tbl%0d_ack", i), {31'b0, ack}, {31'b0, tbl[i].eack});
            chk($sformatf("tbl%0d_dat", i), {24'b0, dat_o}, {24'b0, tbl[i].edat});
        end
        idle(1'b0);

        wr(5'h16, 8'h02, 1'b0);
        repeat (63) idle(1'b1);
        rd("t64_63", 5'h04, 8'h02);
        idle(1'b1);
        rd("t64_64", 5'h04, 8'h01);
        repeat (64) idle(1'b1);
        rd("t64_128", 5'h04, 8'h00);
        repeat (64) idle(1'b1);
        rd("t64_flag", 5'h05, 8'h80);
        rd("t64_192", 5'h04, 8'hFF);
        rd("t64_clr", 5'h05, 8'h00);

        wr(5'h14, 8'h01, 1'b0);
        idle(1'b1);
        cyc(1'b1, 1'b0, 5'h04, 8'h00, 1'b1);
        chk("uf_rd_ack", {31'b0, ack}, 1);
        chk("uf_rd_dat", {24'b0, dat_o}, 0);
        idle(1'b0);
        rd("uf_flag", 5'h05, 8'h80);

`ifdef WB_RIOT_IRQ_EN
        wr(5'h1C, 8'h01, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("irq_set", {31'b0, irq}, 1);
        cyc(1'b1, 1'b0, 5'h04, 8'h00, 1'b0);
        chk("irq_clr", {31'b0, irq}, 0);
        idle(1'b0);
        wr(5'h14, 8'h01, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("irq_off", {31'b0, irq}, 0);
`endif

        hold = 1'b0; rw = 1'b0; ra = '0; rdat = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold && $urandom_range(0, 5) == 0) begin
                hold = 1'b1;
                rw   = ($urandom_range(0, 2) == 0);
                ra   = 5'($urandom_range(0, 31));
                rdat = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 7));
            end
            tk = 1'($urandom_range(0, 1));
            cyc(hold, rw, ra, rdat, tk);
            chk("rnd_ack", {31'b0, ack}, {31'b0, m_ack});
            chk("rnd_dat", {24'b0, dat_o}, {24'b0, m_dat});
`ifdef WB_RIOT_IRQ_EN
            chk("rnd_irq", {31'b0, irq}, {31'b0, m_flag() && m_en});
`endif
            if (m_ack) hold = 1'b0;
        end
        idle(1'b0);

        wr(5'h17, 8'h50, 1'b0);
        repeat (5) idle(1'b1);
        rd("pre_rst", 5'h04, 8'h50);
        @(negedge clk);
        stb = 1'b1; we = 1'b0; adr = 5'h04;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_async_ack", {31'b0, ack}, 0);
        chk("rst_async_dat", {24'b0, dat_o}, 0);
        @(posedge clk);
        #1;
        chk("rst_stb_ack", {31'b0, ack}, 0);
        @(negedge clk);
        rst = 1'b0; stb = 1'b0;
        rd("rst_intim", 5'h04, 8'h00);
        rd("rst_timint", 5'h05, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_riot_timer.md
Name: wb_riot_timer

Overview:
- Wishbone slave (responder) implementing the 6532 RIOT interval timer for the Atari 2600 MCU.
- Sits on the 8-bit wb_bus beside RAM/TIA/ROM and answers CPU-bridge cycles with a registered single-cycle ack.
- Counts on a 6502 cycle enable (tick_i), not on raw clk_i, so the timer tracks the divided CPU rate.
- Provides INTIM/TIMINT reads and TIM1T/TIM8T/TIM64T/T1024T writes.

Parameters:
- RESET_COUNT, 8'h00, timer value after reset.
- RESET_INTERVAL_SEL, 2'd3, interval select after reset (0=1, 1=8, 2=64, 3=1024).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, asynchronous, active-high
- stb_i  input  1  wishbone strobe (cycle request)
- we_i  input  1  1=write, 0=read
- adr_i  input  5  register address (low bits of bus address)
- dat_i  input  8  write data
- ack_o  output  1  wishbone acknowledge
- dat_o  output  8  read data
- tick_i  input  1  one-clk_i pulse per 6502 cycle

Behaviour:
- Reset is asynchronous and active-high on rst_i; all state is clocked on clk_i.
- Reset values: ack_o=0, dat_o=8'h00, count=RESET_COUNT, interval=RESET_INTERVAL_SEL, prescale=0, flag=0.
- Reset asserted mid-count abandons the countdown immediately.
- Handshake:
  - A cycle is accepted on the clk_i edge where stb_i=1 and ack_o=0.
  - ack_o=1 on the next cycle, for exactly one cycle.
  - stb_i held high across ack therefore yields ack every other cycle.
  - Master holds stb_i/we_i/adr_i/dat_i stable until it sees ack.
- Writes, acted on at acceptance:
  - adr_i[4]=1: load count<=dat_i, interval<=adr_i[1:0], prescale<=0, flag<=0.
  - Address map: 0x14 TIM1T, 0x15 TIM8T, 0x16 TIM64T, 0x17 T1024T; 0x18-0x1F mirror.
  - adr_i[4]=0: ignored, still acked.
- Reads, captured at acceptance into dat_o and presented with ack:
  - adr_i[0]=0: INTIM = count.
  - adr_i[0]=1: TIMINT = {flag,7'b0}.
  - adr_i[4:1] are don't-care for reads.
  - dat_o holds its value until the next accepted read.
- Flag clear on read:
  - An accepted INTIM read clears flag.
  - A TIMINT read does not clear flag.
- Counting, only on cycles with tick_i=1:
  - Effective divisor D = 1, 8, 64 or 1024 by interval; forced to 1 while flag=1.
  - If prescale==D-1: prescale<=0 and count<=count-1 (8-bit wrap).
  - Otherwise prescale<=prescale+1.
  - prescale is 10 bits.
- Underflow: a decrement from 8'h00 to 8'hFF sets flag<=1. Counting continues at divisor 1, wrapping 00->FF repeatedly with flag staying set.
- Simultaneous events:
  - Timer write and tick_i in the same cycle: the write wins; load happens, no decrement that cycle.
  - INTIM read accepted in the same cycle as underflow: dat_o=8'h00 (pre-decrement value), flag ends set (set beats clear).
  - stb_i during rst_i: ignored, no ack.

Optional Feature:
- Macro: WB_RIOT_IRQ_EN.
- When defined:
  - Adds output irq_o (1 bit), registered, reset 0.
  - A timer write latches irq_en<=adr_i[3], so 0x1C-0x1F arm the interrupt.
  - irq_o = flag & irq_en; it drops when flag clears or on the next write with adr_i[3]=0.
- When undefined: no irq_o port, no irq_en state; adr_i[3] is don't-care on writes.

Test Plan:
- Reset check: pulse rst_i mid-count after loading 0x50 -> immediately ack_o=0, dat_o=0, INTIM reads 0x00, TIMINT reads 0x00.
- Ack timing: read 0x04 with stb_i held 4 cycles -> ack_o high on cycles 2 and 4 only; a write to 0x00 -> acked, no state change.
- TIM1T: write 0x03 to 0x14, then 3 ticks -> INTIM=0x00, TIMINT=0x00. One more tick -> INTIM=0xFF, TIMINT=0x80. Next tick -> 0xFE.
- TIM64T: write 0x02 to 0x16 -> INTIM stays 0x02 for 63 ticks, 0x01 at tick 64, 0x00 at 128, 0xFF with flag at 192. Then an INTIM read -> TIMINT=0x00 afterwards.
- Collision: timer write coincident with tick_i -> count equals dat_i exactly (no decrement). INTIM read accepted on the underflow tick -> dat_o=0x00 and flag=1.
- WB_RIOT_IRQ_EN: write 0x01 to 0x1C, 2 ticks -> irq_o=1. INTIM read -> irq_o=0 next cycle. Write 0x01 to 0x14, 2 ticks -> irq_o stays 0.
